mul_seq: RTL and testbench
==========================

# mul_seq

Iterative 32x32 -> 64-bit multiplier that initiates operations on the shared combinational ALU instead of owning an adder. It sequences one ALU add per multiplier bit, captures `res`/`zf`, and returns the product as `{hi, lo}`. It sits beside the datapath ALU; the top level muxes the ALU operand and control inputs to this block while `alu_busy` is high.

## Interface
- No parameters; width fixed at 32.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `a`, `b` in 32 each: multiplicand, multiplier.
- `is_signed` in 1: two's-complement operands. Present only with `MUL_SIGNED_EN`.
- `out_valid` out 1: product valid.
- `out_ready` in 1: consumer accepts the product.
- `hi`, `lo` out 32 each: product upper and lower words.
- `alu_busy` out 1: block owns the ALU this cycle.
- `alu_op1`, `alu_op2` out 32 each: ALU operands.
- `alu_con` out 3: ALU control code.
- `alu_res` in 32: ALU result, same-cycle combinational.
- `alu_zf` in 1: ALU zero flag, same-cycle.

## Operation
- **States:** IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI0, NEG_HI1, DONE. The NEG_* states exist only with the macro.
- **IDLE:** `in_ready`=1. On `in_valid`: latch mcand=`a`, lo=`b`, hi=0, cnt=0, then go to ITER, or to NEG_A when the macro is on.
- **ITER:** drive `alu_con`=010 (add), `alu_op1`=hi, `alu_op2`= lo[0] ? mcand : 0.
  - carry = (`alu_res` <u hi), unsigned compare done locally.
  - Update `{hi, lo}` <= `{carry, alu_res, lo[31:1]}`.
  - cnt increments; after the cnt==31 cycle, go to DONE (or NEG_LO).
- **DONE:** `out_valid`=1 with `hi`/`lo` held stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- **ALU bus:** `alu_busy`=1 in every state except IDLE and DONE. Outside those states `alu_op1`/`alu_op2`/`alu_con` are driven 0.
- **Unused ALU codes:** 011 (undefined result) is never issued. The 111 compare is unused.
- **Reset values:** state IDLE; `in_ready`=1. `out_valid`, `alu_busy`, `hi`, `lo`, `alu_op1`, `alu_op2`, `alu_con` all 0.
- **Reset mid-operation:** the operation is abandoned with no `out_valid`. The next cycle is IDLE.

## Timing
- ALU result is consumed in the same cycle it is driven; no ALU pipeline stage.
- **Unsigned latency:** request accepted at edge k; ITER on cycles k+1..k+32; `out_valid` high from cycle k+33.
- Latency is fixed and independent of operand values, including 0.
- `in_ready` is low from the acceptance edge until return to IDLE. There is no request overlap and no bypass.
- **Backpressure:** DONE holds indefinitely. A new request is accepted no earlier than the cycle after the handshake.

## Configuration
- **Macro:** `MUL_SIGNED_EN`.
- **Without it:** unsigned only; the `is_signed` port is absent.
- **With it:**
  - **NEG_A** (1 cycle): con=110, op1=0, op2=mcand. Commit `alu_res` if `is_signed && a[31]`.
  - **NEG_B** (1 cycle): same pattern on lo, committing if `is_signed && b[31]`.
  - **ITER:** unchanged.
  - **Result sign:** neg = `is_signed && (a[31]^b[31])`, latched at accept.
  - **NEG_LO:** 0-lo; capture lo_zero=`alu_zf`.
  - **NEG_HI0:** 0-hi.
  - **NEG_HI1:** con=110, op1=NEG_HI0 result, op2= lo_zero ? 0 : 1.
  - Each result commits only if neg.
  - **Latency:** fixed at 38 (`out_valid` from k+38) whenever the macro is on, regardless of `is_signed`.
  - **Edge case:** -2^31 negates to 0x80000000, which is the correct unsigned magnitude.

## Structure
- **Shared package `alu_pkg`:**
  - ALU control constants ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_ANDN=100, ALU_ORN=101, ALU_SUB=110, ALU_SLT=111.
  - `mul_state_t` enum.
- The ALU is not instantiated inside this block; the top level wires it.
- No sub-module; the counter and the carry compare are inline.

## Test plan
- **Small unsigned:** a=3, b=5, unsigned -> hi=0, lo=15; `out_valid` exactly at k+33 (k+38 with the macro).
- **Max unsigned:** a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Exercises carry every iteration.
- **Signed (macro):**
  - -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - 0x80000000 * 0xFFFFFFFF signed -> hi=0, lo=0x80000000.
  - 0 * -7 -> hi=lo=0.
- **Backpressure:** `out_ready` low for 10 cycles after `out_valid` -> `hi`/`lo`/`out_valid` stable, `in_ready`=0. Handshake, then `in_ready`=1 the next cycle.
- **Reset mid-op:** assert `reset` at ITER cycle 10 -> `out_valid` never rises; next cycle `in_ready`=1 and `alu_busy`=0. A fresh 7*6 returns lo=42.
- **ALU ownership:** monitor during any op -> `alu_con` is never 011; `alu_busy`=0 exactly in IDLE and DONE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes and the sequential multiplier state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NEG_A   = 3'd1,
        NEG_B   = 3'd2,
        ITER    = 3'd3,
        NEG_LO  = 3'd4,
        NEG_HI0 = 3'd5,
        NEG_HI1 = 3'd6,
        DONE    = 3'd7
    } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative 32x32->64 shift-add multiplier that borrows the shared datapath ALU.
// Define MUL_SIGNED_EN to add the is_signed port and two's-complement sign fixup.
module mul_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MUL_SIGNED_EN
    input  logic        is_signed,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_busy,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [2:0]  alu_con,
    input  logic [31:0] alu_res,
    input  logic        alu_zf
);

    mul_state_t  state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        carry;

`ifdef MUL_SIGNED_EN
    logic        a_neg_q, a_neg_d;
    logic        b_neg_q, b_neg_d;
    logic        neg_q, neg_d;
    logic        lo_zero_q, lo_zero_d;
`else
    logic        unused_zf;
    assign unused_zf = alu_zf;
`endif

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        carry     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_busy  = 1'b0;
        alu_op1   = 32'd0;
        alu_op2   = 32'd0;
        alu_con   = 3'b000;
`ifdef MUL_SIGNED_EN
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        neg_d     = neg_q;
        lo_zero_d = lo_zero_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = 32'd0;
                    cnt_d   = 5'd0;
`ifdef MUL_SIGNED_EN
                    a_neg_d = is_signed & a[31];
                    b_neg_d = is_signed & b[31];
                    neg_d   = is_signed & (a[31] ^ b[31]);
                    state_d = NEG_A;
`else
                    state_d = ITER;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            NEG_A: begin
                alu_busy = 1'b1;
                alu_con  = ALU_SUB;
                alu_op2  = mcand_q;
                if (a_neg_q) mcand_d = alu_res;
                state_d  = NEG_B;
            end
            NEG_B: begin
                alu_busy = 1'b1;
                alu_con  = ALU_SUB;
                alu_op2  = lo_q;
                if (b_neg_q) lo_d = alu_res;
                state_d  = ITER;
            end
`endif
            ITER: begin
                alu_busy = 1'b1;
                alu_con  = ALU_ADD;
                alu_op1  = hi_q;
                alu_op2  = lo_q[0] ? mcand_q : 32'd0;
                // A 32-bit add wrapped iff the sum is below either addend.
                carry    = (alu_res < hi_q);
                hi_d     = {carry, alu_res[31:1]};
                lo_d     = {alu_res[0], lo_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
`ifdef MUL_SIGNED_EN
                    state_d = NEG_LO;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            NEG_LO: begin
                alu_busy  = 1'b1;
                alu_con   = ALU_SUB;
                alu_op2   = lo_q;
                lo_zero_d = alu_zf;
                if (neg_q) lo_d = alu_res;
                state_d   = NEG_HI0;
            end
            NEG_HI0: begin
                alu_busy = 1'b1;
                alu_con  = ALU_SUB;
                alu_op2  = hi_q;
                if (neg_q) hi_d = alu_res;
                state_d  = NEG_HI1;
            end
            // -{hi,lo} = {~hi + (lo==0), -lo} = {-hi - (lo!=0), -lo}
            NEG_HI1: begin
                alu_busy = 1'b1;
                alu_con  = ALU_SUB;
                alu_op1  = hi_q;
                alu_op2  = lo_zero_q ? 32'd0 : 32'd1;
                if (neg_q) hi_d = alu_res;
                state_d  = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            cnt_q     <= 5'd0;
`ifdef MUL_SIGNED_EN
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            neg_q     <= 1'b0;
            lo_zero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
`ifdef MUL_SIGNED_EN
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            neg_q     <= neg_d;
            lo_zero_q <= lo_zero_d;
`endif
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: a behavioural ALU answers the block's requests and
// every product, latency and handshake observation is compared against hand-computed values.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MUL_SIGNED_EN
    logic        is_signed;
    // NEG_A + NEG_B + 32 ITER + NEG_LO + NEG_HI0 + NEG_HI1 busy cycles
    localparam int BUSY_CYCLES = 37;
`else
    localparam int BUSY_CYCLES = 32;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_busy;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [2:0]  alu_con;
    logic [31:0] alu_res;
    logic        alu_zf;

    int checkCount = 0;
    int failCount = 0;
    int ownViolations = 0;
    bit monitorOn = 1'b0;

    mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef MUL_SIGNED_EN
        .is_signed (is_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hi        (hi),
        .lo        (lo),
        .alu_busy  (alu_busy),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_con   (alu_con),
        .alu_res   (alu_res),
        .alu_zf    (alu_zf)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared datapath ALU; the undefined code returns a poison value.
    function automatic logic [31:0] aluModel(input logic [2:0] con, input logic [31:0] x, input logic [31:0] y);
        case (con)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b100:  return x & ~y;
            3'b101:  return x | ~y;
            3'b110:  return x - y;
            3'b111:  return {31'd0, $signed(x) < $signed(y)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_res = aluModel(alu_con, alu_op1, alu_op2);
    assign alu_zf  = (alu_res == 32'd0);

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ALU ownership: busy exactly outside IDLE/DONE, bus idle when not busy, never code 011.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (alu_con === 3'b011) ownViolations++;
            if (alu_busy !== !(in_ready || out_valid)) ownViolations++;
            if (!alu_busy && ({alu_con, alu_op1, alu_op2} !== 67'd0)) ownViolations++;
        end
    end

    // One full transaction: request, wait for the product, optional backpressure, handshake.
    task automatic applyStimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv, input logic [31:0] expHi, input logic [31:0] expLo,
                                 input int holdCycles);
        int lat;
        $display("[TB] %s a=%h b=%h signed=%0d", tag, av, bv, sv);
        @(negedge clk);
        checkOutput({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
`ifdef MUL_SIGNED_EN
        is_signed = sv;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
`ifdef MUL_SIGNED_EN
        is_signed = ~sv;
`endif
        checkOutput({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(BUSY_CYCLES));
        checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_hold_prod"}, {hi, lo}, {expHi, expLo});
            checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_after_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_after_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got=running expected=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int seen;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 32'd0;
        b = 32'd0;
`ifdef MUL_SIGNED_EN
        is_signed = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_alu_busy", 64'(alu_busy), 64'd0);
        checkOutput("rst_prod", {hi, lo}, 64'd0);
        checkOutput("rst_alu_bus", {29'd0, alu_con, alu_op1, alu_op2} , 64'd0);
        reset = 1'b0;
        monitorOn = 1'b1;

        applyStimulus("small", 32'd3, 32'd5, 1'b0, 32'd0, 32'd15, 0);
        applyStimulus("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        applyStimulus("zero", 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        applyStimulus("backpressure", 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd1, 32'd0, 10);
        applyStimulus("msb_unsigned", 32'h8000_0000, 32'd2, 1'b0, 32'd1, 32'd0, 0);
`ifdef MUL_SIGNED_EN
        applyStimulus("neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        applyStimulus("minxneg1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 0);
        applyStimulus("zeroxneg7", 32'd0, 32'hFFFF_FFF9, 1'b1, 32'd0, 32'd0, 0);
        applyStimulus("neg2xneg3", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 32'd0, 32'd6, 0);
`endif

        // Abandon an operation partway through the iterations.
        @(negedge clk);
        a = 32'd100;
        b = 32'd200;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (BUSY_CYCLES - 22) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_alu_busy", 64'(alu_busy), 64'd0);
        checkOutput("midrst_prod", {hi, lo}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_valid", 64'(seen), 64'd0);
        applyStimulus("fresh7x6", 32'd7, 32'd6, 1'b0, 32'd0, 32'd42, 0);

        monitorOn = 1'b0;
        checkOutput("alu_ownership", 64'(ownViolations), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
